elevator_scheduler: RTL

Request scheduler that sits in front of the single-car elevator controller. It latches floor calls into a pending bitmap and drives the controller's floor-request input with one target at a time. Targets are chosen by LOOK ordering: keep serving calls in the current sweep direction, then reverse. The scheduler also holds the door open for a dwell period at each stop and freezes dispatch during emergency.

---
 rtl/elevator_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: LOOK-ordered floor request scheduler with door dwell and emergency halt.
// Define SCHED_FLOOR_LOCK_EN to add lock_mask, which blocks calls to and selection of locked floors.
module elevator_scheduler #(
    parameter int NUM_FLOORS   = 16,
    parameter int FLOOR_W      = 4,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Emergency,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
`ifdef SCHED_FLOOR_LOCK_EN
    input  logic [NUM_FLOORS-1:0] lock_mask,
`endif
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_up,
    output logic                  busy,
    output logic                  call_reject
);
    localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, DWELL, HALT} state_t;

    state_t                state, state_n;
    logic [FLOOR_W-1:0]    target_n, sel, up_lo, below_hi, down_hi, above_lo;
    logic                  up_lo_ok, down_hi_ok, sel_ok, sel_up, sweep_n, call_bad, arrive;
    logic [NUM_FLOORS-1:0] eligible, pending_n, clr_mask, call_bit, cur_bit, tgt_bit;
    logic [CW-1:0]         cnt, cnt_n;

    // A shifted-out one means the call index is beyond the last served floor.
    assign call_bit = NUM_FLOORS'(1) << call_floor;
    assign cur_bit  = NUM_FLOORS'(1) << current_floor;
    assign tgt_bit  = NUM_FLOORS'(1) << target_floor;
`ifdef SCHED_FLOOR_LOCK_EN
    assign eligible = pending & ~lock_mask;
    assign call_bad = call_bit == '0 || |(call_bit & lock_mask);
`else
    assign eligible = pending;
    assign call_bad = call_bit == '0;
`endif
    assign arrive       = state == SERVE && current_floor == target_floor && door_open && |(eligible & tgt_bit);
    assign target_valid = state == SERVE;
    assign busy         = state != IDLE;

    always_comb begin
        up_lo_ok   = 1'b0;
        down_hi_ok = 1'b0;
        up_lo      = '0;
        below_hi   = '0;
        down_hi    = '0;
        above_lo   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (eligible[i] && FLOOR_W'(i) >= current_floor && !up_lo_ok) begin
                up_lo_ok = 1'b1;
                up_lo    = FLOOR_W'(i);
            end
            if (eligible[i] && FLOOR_W'(i) < current_floor) below_hi = FLOOR_W'(i);
            if (eligible[i] && FLOOR_W'(i) <= current_floor) begin
                down_hi_ok = 1'b1;
                down_hi    = FLOOR_W'(i);
            end
            if (eligible[i] && FLOOR_W'(i) > current_floor && above_lo == '0 && FLOOR_W'(i) != '0) above_lo = FLOOR_W'(i);
        end
        sel_ok = |eligible;
        sel    = sweep_up ? (up_lo_ok ? up_lo : below_hi) : (down_hi_ok ? down_hi : above_lo);
        sel_up = sweep_up ? up_lo_ok : !down_hi_ok;
    end

    always_comb begin
        state_n  = state;
        target_n = target_floor;
        sweep_n  = sweep_up;
        cnt_n    = cnt;
        clr_mask = '0;
        if (Emergency) begin
            state_n  = HALT;
            target_n = current_floor;
        end else begin
            case (state)
                IDLE: if (sel_ok) begin
                    state_n  = SERVE;
                    target_n = sel;
                    sweep_n  = sel_up;
                end
                SERVE: if (arrive) begin
                    clr_mask = tgt_bit;
                    cnt_n    = CW'(DWELL_CYCLES - 1);
                    state_n  = DWELL;
                end else if (sel_ok) begin
                    target_n = sel;
                    sweep_n  = sel_up;
                end else begin
                    state_n = IDLE;
                end
                // Clearing the current floor every dwell cycle absorbs late calls to it.
                DWELL: begin
                    clr_mask = cur_bit;
                    target_n = current_floor;
                    if (cnt == '0) state_n = IDLE;
                    else cnt_n = cnt - CW'(1);
                end
                HALT: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
        pending_n = (pending | (call_valid && !call_bad ? call_bit : '0)) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            target_floor <= '0;
            pending      <= '0;
            sweep_up     <= 1'b1;
            cnt          <= '0;
            call_reject  <= 1'b0;
        end else begin
            state        <= state_n;
            target_floor <= target_n;
            pending      <= pending_n;
            sweep_up     <= sweep_n;
            cnt          <= cnt_n;
            call_reject  <= call_valid && call_bad;
        end
    end
endmodule
